mux_scan_ctrl: RTL



---
 rtl/mux_scan_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Scans an N:1 mux select, samples each channel after a dwell time and delivers a valid/ready frame.
// Optional build macro MUX_SCAN_CHANGE_EN: suppress delivery of frames identical to the last delivered one.
module mux_scan_ctrl #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned DWELL  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_o,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] frame_d;
  logic              valid_d;
  logic              busy_d;

`ifdef MUX_SCAN_CHANGE_EN
  logic [NUM_CH-1:0] last_q, last_d;
  logic              first_q, first_d;
`endif

  // State and datapath registers; reset drops any partial scan at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel         <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef MUX_SCAN_CHANGE_EN
      last_q      <= '0;
      first_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel         <= sel_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      frame       <= frame_d;
      frame_valid <= valid_d;
      busy        <= busy_d;
`ifdef MUX_SCAN_CHANGE_EN
      last_q      <= last_d;
      first_q     <= first_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = frame;
    valid_d  = frame_valid;
`ifdef MUX_SCAN_CHANGE_EN
    last_d   = last_q;
    first_d  = first_q;
`endif

    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d = SETTLE;
          cnt_d   = CNT_LOAD;
        end
      end

      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) shadow_d[k] = mux_o;
          end
          if (sel != SEL_LAST) begin
            sel_d = sel + SEL_W'(1);
            cnt_d = CNT_LOAD;
          end else begin
            sel_d = '0;
`ifdef MUX_SCAN_CHANGE_EN
            // An unchanged frame is dropped and the scanner moves straight on.
            if (first_q && (shadow_d == last_q)) begin
              state_d = continuous ? SETTLE : IDLE;
              cnt_d   = CNT_LOAD;
            end else begin
              frame_d = shadow_d;
              valid_d = 1'b1;
              state_d = HOLD;
              last_d  = shadow_d;
              first_d = 1'b1;
            end
`else
            frame_d = shadow_d;
            valid_d = 1'b1;
            state_d = HOLD;
`endif
          end
        end
      end

      HOLD: begin
        if (frame_valid && frame_ready) begin
          valid_d = 1'b0;
          sel_d   = '0;
          if (continuous) begin
            state_d = SETTLE;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
